// File: rtl/rename_alloc_ctrl_pkg.sv
// Shared sizing defaults and register/tag types for the rename allocator slice.
package rename_alloc_ctrl_pkg;
   localparam int unsigned DEF_NUM_ARCH  = 32;
   localparam int unsigned DEF_NUM_PHYS  = 128;
   localparam int unsigned DEF_ROB_DEPTH = 16;
   localparam int unsigned DEF_PW        = $clog2(DEF_NUM_PHYS);
   localparam int unsigned DEF_TW        = $clog2(DEF_ROB_DEPTH);

   typedef logic [DEF_PW-1:0] preg_t;
   typedef logic [DEF_TW-1:0] rob_tag_t;
endpackage

// File: rtl/rename_alloc_ctrl_if.sv
// Rename request/grant and commit channel between the rename stage and the allocator.
interface rename_alloc_ctrl_if
   import rename_alloc_ctrl_pkg::*;
#(
   parameter int unsigned PW = DEF_PW,
   parameter int unsigned TW = DEF_TW
);
   logic          rn_valid;
   logic          rn_need_prd;
   logic          ds_ready;
   logic          rn_ready;
   logic [PW-1:0] alloc_prd;
   logic [TW-1:0] alloc_rob_tag;
   logic          cm_valid;
   logic          cm_free_valid;
   logic [PW-1:0] cm_old_prd;

   modport master (
      output rn_valid, rn_need_prd, ds_ready, cm_valid, cm_free_valid, cm_old_prd,
      input  rn_ready, alloc_prd, alloc_rob_tag
   );

   modport slave (
      input  rn_valid, rn_need_prd, ds_ready, cm_valid, cm_free_valid, cm_old_prd,
      output rn_ready, alloc_prd, alloc_rob_tag
   );
endinterface

// File: rtl/rename_alloc_ctrl_free_list_fifo.sv
// Circular free-PRD store with speculative head, architectural head and tail pointers.
module free_list_fifo
   import rename_alloc_ctrl_pkg::*;
#(
   parameter int unsigned NUM_ARCH = DEF_NUM_ARCH,
   parameter int unsigned NUM_PHYS = DEF_NUM_PHYS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        alloc,
   input  logic                        free_valid,
   input  logic [$clog2(NUM_PHYS)-1:0] free_prd,
   input  logic                        restore,
   output logic [$clog2(NUM_PHYS)-1:0] head_prd,
   output logic [$clog2(NUM_PHYS):0]   count
);
   localparam int unsigned FL_DEPTH = NUM_PHYS - NUM_ARCH;
   localparam int unsigned PW       = $clog2(NUM_PHYS);
   localparam int unsigned FPW      = (FL_DEPTH > 1) ? $clog2(FL_DEPTH) : 1;

   logic [PW-1:0]  fl [FL_DEPTH];
   logic [FPW-1:0] spec_head, arch_head, tail;
   logic [FPW-1:0] arch_head_nxt;

   // Depth need not be a power of two, so wrap by compare rather than overflow.
   function automatic logic [FPW-1:0] fl_inc(input logic [FPW-1:0] p);
      return (p == FPW'(FL_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      arch_head_nxt = free_valid ? fl_inc(arch_head) : arch_head;
      head_prd      = fl[spec_head];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < FL_DEPTH; i++) begin
            fl[i] <= PW'(NUM_ARCH + i);
         end
         spec_head <= '0;
         arch_head <= '0;
         tail      <= '0;
         count     <= (PW+1)'(FL_DEPTH);
      end else begin
         if (free_valid) begin
            fl[tail] <= free_prd;
            tail     <= fl_inc(tail);
         end
         arch_head <= arch_head_nxt;
         if (restore) begin
            // Roll back to the committed head including any free in this same cycle.
            spec_head <= arch_head_nxt;
            count     <= (PW+1)'(FL_DEPTH);
         end else begin
            if (alloc) spec_head <= fl_inc(spec_head);
            unique case ({alloc, free_valid})
               2'b10:   count <= count - 1'b1;
               2'b01:   count <= count + 1'b1;
               default: count <= count;
            endcase
         end
      end
   end
endmodule

// File: rtl/rename_alloc_ctrl.sv
// Rename-stage allocator: grants a PRD and ROB tag per instruction, reclaims at commit, rolls back on flush.
module rename_alloc_ctrl
   import rename_alloc_ctrl_pkg::*;
#(
   parameter int unsigned NUM_ARCH  = DEF_NUM_ARCH,
   parameter int unsigned NUM_PHYS  = DEF_NUM_PHYS,
   parameter int unsigned ROB_DEPTH = DEF_ROB_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   rename_alloc_ctrl_if.slave           bus,
   input  logic                         flush,
   output logic [$clog2(NUM_PHYS):0]    fl_count,
   output logic [$clog2(ROB_DEPTH):0]   rob_count,
   output logic                         err_underflow
);
   localparam int unsigned PW = $clog2(NUM_PHYS);
   localparam int unsigned TW = $clog2(ROB_DEPTH);

   logic [TW-1:0] rob_head, rob_tail, rob_head_nxt;
   logic [PW-1:0] fl_head_prd;
   logic          rob_full, fire, cm_ok, fl_alloc, fl_free;

   function automatic logic [TW-1:0] rob_inc(input logic [TW-1:0] p);
      return (p == TW'(ROB_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      rob_full          = (rob_count == (TW+1)'(ROB_DEPTH));
      bus.rn_ready      = bus.ds_ready & ~flush & ~rob_full &
                          (~bus.rn_need_prd | (fl_count != '0));
      fire              = bus.rn_valid & bus.rn_ready;
      bus.alloc_prd     = bus.rn_need_prd ? fl_head_prd : '0;
      bus.alloc_rob_tag = rob_tail;
      cm_ok             = bus.cm_valid & (rob_count != '0);
      fl_alloc          = fire & bus.rn_need_prd;
      fl_free           = cm_ok & bus.cm_free_valid;
      rob_head_nxt      = cm_ok ? rob_inc(rob_head) : rob_head;
   end

   free_list_fifo #(
      .NUM_ARCH (NUM_ARCH),
      .NUM_PHYS (NUM_PHYS)
   ) u_free_list (
      .clk        (clk),
      .rst        (rst),
      .alloc      (fl_alloc),
      .free_valid (fl_free),
      .free_prd   (bus.cm_old_prd),
      .restore    (flush),
      .head_prd   (fl_head_prd),
      .count      (fl_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rob_head      <= '0;
         rob_tail      <= '0;
         rob_count     <= '0;
         err_underflow <= 1'b0;
      end else begin
         rob_head <= rob_head_nxt;
         if (flush) begin
            rob_tail  <= rob_head_nxt;
            rob_count <= '0;
         end else begin
            if (fire) rob_tail <= rob_inc(rob_tail);
            unique case ({fire, cm_ok})
               2'b10:   rob_count <= rob_count + 1'b1;
               2'b01:   rob_count <= rob_count - 1'b1;
               default: rob_count <= rob_count;
            endcase
         end
         if (bus.cm_valid && rob_count == '0) err_underflow <= 1'b1;
      end
   end
endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Directed self-checking bench for rename_alloc_ctrl (default sizing plus a 40-PRD instance).
module tb_rename_alloc_ctrl;
   import rename_alloc_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       flush = 1'b0;
   logic       flush_s = 1'b0;
   logic [7:0] fl_count;
   logic [4:0] rob_count;
   logic       err_underflow;
   logic [6:0] fl_count_s;
   logic [4:0] rob_count_s;
   logic       err_underflow_s;
   int         n_tests = 0;
   int         n_fail  = 0;

   always #5 clk = ~clk;

   rename_alloc_ctrl_if #(.PW(7), .TW(4)) bus  ();
   rename_alloc_ctrl_if #(.PW(6), .TW(4)) sbus ();

   rename_alloc_ctrl #(.NUM_ARCH(32), .NUM_PHYS(128), .ROB_DEPTH(16)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .flush         (flush),
      .fl_count      (fl_count),
      .rob_count     (rob_count),
      .err_underflow (err_underflow)
   );

   rename_alloc_ctrl #(.NUM_ARCH(32), .NUM_PHYS(40), .ROB_DEPTH(16)) u_small (
      .clk           (clk),
      .rst           (rst),
      .bus           (sbus),
      .flush         (flush_s),
      .fl_count      (fl_count_s),
      .rob_count     (rob_count_s),
      .err_underflow (err_underflow_s)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic drv(input logic v, input logic need, input logic ds, input logic cmv,
                      input logic cmf, input logic [6:0] old, input logic fl);
      bus.rn_valid      = v;
      bus.rn_need_prd   = need;
      bus.ds_ready      = ds;
      bus.cm_valid      = cmv;
      bus.cm_free_valid = cmf;
      bus.cm_old_prd    = old;
      flush             = fl;
   endtask

   task automatic sdrv(input logic v, input logic need, input logic cmv,
                       input logic cmf, input logic [5:0] old);
      sbus.rn_valid      = v;
      sbus.rn_need_prd   = need;
      sbus.ds_ready      = 1'b1;
      sbus.cm_valid      = cmv;
      sbus.cm_free_valid = cmf;
      sbus.cm_old_prd    = old;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      tick();
   endtask

   initial begin
      drv(0, 0, 1, 0, 0, 0, 0);
      sdrv(0, 0, 0, 0, 0);
      #12;
      check("rst_fl_count", 32'(fl_count), 32'd96);
      check("rst_rob_count", 32'(rob_count), 32'd0);
      check("rst_err", 32'(err_underflow), 32'd0);
      check("rst_small_fl_count", 32'(fl_count_s), 32'd8);
      rst = 1'b1;
      tick();

      // 1: four PRD-writing instructions then a branch
      for (int i = 0; i < 5; i++) begin
         drv(1, (i < 4), 1, 0, 0, 0, 0);
         #1;
         check("t1_ready", 32'(bus.rn_ready), 32'd1);
         check("t1_prd", 32'(bus.alloc_prd), (i < 4) ? 32'(32 + i) : 32'd0);
         check("t1_tag", 32'(bus.alloc_rob_tag), 32'(i));
         tick();
      end
      drv(0, 0, 1, 0, 0, 0, 0);
      check("t1_fl_count", 32'(fl_count), 32'd92);
      check("t1_rob_count", 32'(rob_count), 32'd5);

      // 2: downstream backpressure
      do_reset();
      drv(1, 1, 0, 0, 0, 0, 0);
      #1;
      check("t2_stall_ready", 32'(bus.rn_ready), 32'd0);
      tick();
      check("t2_stall_fl", 32'(fl_count), 32'd96);
      check("t2_stall_rob", 32'(rob_count), 32'd0);
      drv(1, 1, 1, 0, 0, 0, 0);
      #1;
      check("t2_go_ready", 32'(bus.rn_ready), 32'd1);
      check("t2_go_prd", 32'(bus.alloc_prd), 32'd32);
      check("t2_go_tag", 32'(bus.alloc_rob_tag), 32'd0);
      tick();
      drv(0, 0, 1, 0, 0, 0, 0);
      check("t2_fl_after", 32'(fl_count), 32'd95);
      check("t2_rob_after", 32'(rob_count), 32'd1);

      // 3: fill the ROB, then one commit frees a tag that wraps to 0
      do_reset();
      for (int i = 0; i < 16; i++) begin
         drv(1, 1, 1, 0, 0, 0, 0);
         #1;
         check("t3_fill_tag", 32'(bus.alloc_rob_tag), 32'(i));
         tick();
      end
      drv(1, 1, 1, 0, 0, 0, 0);
      #1;
      check("t3_full_ready", 32'(bus.rn_ready), 32'd0);
      check("t3_full_rob", 32'(rob_count), 32'd16);
      check("t3_full_fl", 32'(fl_count), 32'd80);
      tick();
      drv(1, 1, 1, 1, 0, 0, 0);
      #1;
      check("t3_commit_ready", 32'(bus.rn_ready), 32'd0);
      tick();
      drv(1, 1, 1, 0, 0, 0, 0);
      #1;
      check("t3_wrap_rob", 32'(rob_count), 32'd15);
      check("t3_wrap_ready", 32'(bus.rn_ready), 32'd1);
      check("t3_wrap_tag", 32'(bus.alloc_rob_tag), 32'd0);
      tick();
      drv(0, 0, 1, 0, 0, 0, 0);
      check("t3_refill_rob", 32'(rob_count), 32'd16);

      // 4: 8-entry free list drains, stalls, then a freed PRD is reused after one cycle
      do_reset();
      for (int i = 0; i < 8; i++) begin
         sdrv(1, 1, (i % 2 == 1), 0, 0);
         #1;
         check("t4_prd", 32'(sbus.alloc_prd), 32'(32 + i));
         tick();
      end
      sdrv(1, 1, 0, 0, 0);
      #1;
      check("t4_empty_ready", 32'(sbus.rn_ready), 32'd0);
      check("t4_empty_fl", 32'(fl_count_s), 32'd0);
      check("t4_rob", 32'(rob_count_s), 32'd4);
      tick();
      sdrv(1, 1, 1, 1, 6'd5);
      #1;
      check("t4_nobypass_ready", 32'(sbus.rn_ready), 32'd0);
      tick();
      sdrv(1, 1, 0, 0, 0);
      #1;
      check("t4_reuse_fl", 32'(fl_count_s), 32'd1);
      check("t4_reuse_ready", 32'(sbus.rn_ready), 32'd1);
      check("t4_reuse_prd", 32'(sbus.alloc_prd), 32'd5);
      tick();
      sdrv(0, 0, 0, 0, 0);
      check("t4_end_fl", 32'(fl_count_s), 32'd0);
      check("t4_end_rob", 32'(rob_count_s), 32'd4);

      // 5: commit freeing P1 together with a flush
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drv(1, 1, 1, 0, 0, 0, 0);
         tick();
      end
      drv(1, 1, 1, 1, 1, 7'd1, 1);
      #1;
      check("t5_flush_ready", 32'(bus.rn_ready), 32'd0);
      tick();
      drv(1, 1, 1, 0, 0, 0, 0);
      #1;
      check("t5_flush_rob", 32'(rob_count), 32'd0);
      check("t5_flush_fl", 32'(fl_count), 32'd96);
      check("t5_next_ready", 32'(bus.rn_ready), 32'd1);
      check("t5_next_prd", 32'(bus.alloc_prd), 32'd33);
      check("t5_next_tag", 32'(bus.alloc_rob_tag), 32'd1);
      tick();
      drv(0, 0, 1, 0, 0, 0, 0);
      check("t5_after_fl", 32'(fl_count), 32'd95);
      check("t5_after_rob", 32'(rob_count), 32'd1);

      // 6: commit with an empty ROB, then an asynchronous reset mid-stream
      do_reset();
      drv(0, 1, 1, 1, 1, 7'd7, 0);
      tick();
      drv(0, 1, 1, 0, 0, 0, 0);
      #1;
      check("t6_err", 32'(err_underflow), 32'd1);
      check("t6_rob", 32'(rob_count), 32'd0);
      check("t6_fl", 32'(fl_count), 32'd96);
      check("t6_tag", 32'(bus.alloc_rob_tag), 32'd0);
      check("t6_prd", 32'(bus.alloc_prd), 32'd32);
      tick();
      tick();
      check("t6_err_sticky", 32'(err_underflow), 32'd1);
      for (int i = 0; i < 2; i++) begin
         drv(1, 1, 1, 0, 0, 0, 0);
         tick();
      end
      drv(0, 1, 1, 0, 0, 0, 0);
      check("t6_pre_rob", 32'(rob_count), 32'd2);
      rst = 1'b0;
      #2;
      check("t6_arst_fl", 32'(fl_count), 32'd96);
      check("t6_arst_rob", 32'(rob_count), 32'd0);
      check("t6_arst_err", 32'(err_underflow), 32'd0);
      check("t6_arst_tag", 32'(bus.alloc_rob_tag), 32'd0);
      check("t6_arst_prd", 32'(bus.alloc_prd), 32'd32);
      rst = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
